// File: rtl/hwag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwag_pkg
// Description : Shared definitions for the crank tooth capture block:
//               default geometry constants (timer width, tooth index width,
//               physical teeth on a 60-2 wheel) and the capture state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package hwag_pkg;

    // Default period timer / captured period width in bits.
    localparam int c_width_default   = 24;
    // Default tooth index width in bits.
    localparam int c_tooth_w_default = 6;
    // Physical teeth per revolution on a 60-2 wheel.
    localparam int c_teeth_default   = 58;

    // Capture / synchronisation states.
    //   ST_IDLE   : no timing reference (after reset or a timer stall)
    //   ST_ARM    : one edge seen, timer is measuring the first period
    //   ST_FILL   : one period captured, period_prev not yet meaningful
    //   ST_SEARCH : looking for the missing-teeth gap
    //   ST_SYNC   : wheel position locked, tooth index is meaningful
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_FILL   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_SYNC   = 3'd4
    } state_e;

endpackage : hwag_pkg
`default_nettype wire

// File: rtl/hwag_gap_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hwag_gap_cmp
// Description : Combinational gap test. Asserts o_gt when the candidate
//               period is strictly greater than twice the previous period.
//               Both operands are widened to WIDTH+1 bits so that doubling
//               the previous period can never overflow.
// Ports       : i_period      [WIDTH-1:0] candidate (newest) period
//               i_period_prev [WIDTH-1:0] period captured before it
//               o_gt          1           candidate > 2 * previous
// Revision    : 1.0 - initial release
// ============================================================================
module hwag_gap_cmp
    import hwag_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_period_prev,
    output logic             o_gt
);

    logic [WIDTH:0] w_candidate;
    logic [WIDTH:0] w_twice_prev;

    assign w_candidate  = {1'b0, i_period};
    // Doubling is a left shift into the extra top bit.
    assign w_twice_prev = {i_period_prev, 1'b0};
    assign o_gt         = (w_candidate > w_twice_prev);

endmodule : hwag_gap_cmp
`default_nettype wire

// File: rtl/tooth_capture.sv
`default_nettype none
// ============================================================================
// Module      : tooth_capture
// Description : Crank tooth period capture and missing-tooth synchroniser.
//               A saturating timer measures the clk cycles between filtered
//               tooth edges. Each accepted edge registers the measured
//               period (one cycle latency), shifts the old period into
//               period_prev and runs a gap test (period > 2*period_prev).
//               A state machine locks onto the wheel gap and then tracks the
//               tooth index, dropping lock on a missing or early gap. A timer
//               that saturates (no edge for 2**WIDTH-1 cycles) flags stall
//               and discards the timing reference.
// Ports       : clk         in   1        sole clock, rising edge
//               rst         in   1        asynchronous active-high reset
//               ena         in   1        enable; low freezes all state
//               edge_pulse  in   1        one-cycle filtered tooth edge pulse
//               cap_valid   out  1        pulse: new period registered
//               period      out  WIDTH    last captured period (clk cycles)
//               period_prev out  WIDTH    period captured before period
//               gap         out  1        pulse with cap_valid: period is a gap
//               tooth       out  TOOTH_W  tooth that closed the last period
//               sync        out  1        level: wheel position locked
//               stall       out  1        level: timer saturated
// Revision    : 1.0 - initial release
// ============================================================================
module tooth_capture
    import hwag_pkg::*;
#(
    parameter int WIDTH   = c_width_default,
    parameter int TOOTH_W = c_tooth_w_default,
    parameter int TEETH   = c_teeth_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    // The tooth edge input cannot be called plain "edge": that is a
    // reserved word in SystemVerilog.
    input  logic               edge_pulse,
    output logic               cap_valid,
    output logic [WIDTH-1:0]   period,
    output logic [WIDTH-1:0]   period_prev,
    output logic               gap,
    output logic [TOOTH_W-1:0] tooth,
    output logic               sync,
    output logic               stall
);

    localparam logic [WIDTH-1:0]   c_timer_max  = '1;
    localparam logic [TOOTH_W-1:0] c_last_tooth = TOOTH_W'(TEETH - 1);

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_timer;
    logic [WIDTH-1:0]   w_timer_nxt;
    logic [WIDTH-1:0]   r_period;
    logic [WIDTH-1:0]   w_period_nxt;
    logic [WIDTH-1:0]   r_period_prev;
    logic [WIDTH-1:0]   w_period_prev_nxt;
    logic [TOOTH_W-1:0] r_tooth;
    logic [TOOTH_W-1:0] w_tooth_nxt;
    logic               r_cap_valid;
    logic               w_cap_valid_nxt;
    logic               r_gap;
    logic               w_gap_nxt;
    logic               r_stall;
    logic               w_stall_nxt;

    logic               w_timer_sat;
    logic               w_is_gap;

    assign w_timer_sat = (r_timer == c_timer_max);

    // The gap test looks at the period about to be captured (the live
    // timer) against the period it will displace into period_prev.
    hwag_gap_cmp #(
        .WIDTH (WIDTH)
    ) u_gap_cmp (
        .i_period      (r_timer),
        .i_period_prev (r_period),
        .o_gt          (w_is_gap)
    );

    // ------------------------------------------------------------------
    // Next-state and capture logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_period_nxt      = r_period;
        w_period_prev_nxt = r_period_prev;
        w_tooth_nxt       = r_tooth;
        w_stall_nxt       = r_stall;
        w_cap_valid_nxt   = 1'b0;
        w_gap_nxt         = 1'b0;

        if (ena) begin
            if (edge_pulse) begin
                w_timer_nxt = WIDTH'(1);
                w_stall_nxt = 1'b0;
                // With no prior edge, or a saturated timer, the timer holds
                // no meaningful period: this edge only starts a measurement.
                if ((r_state == ST_IDLE) || w_timer_sat) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_cap_valid_nxt   = 1'b1;
                    w_period_nxt      = r_timer;
                    w_period_prev_nxt = r_period;
                    unique case (r_state)
                        ST_ARM: begin
                            w_state_nxt = ST_FILL;
                        end
                        ST_FILL: begin
                            // This capture makes period_prev valid; gap
                            // testing starts from the next capture.
                            w_state_nxt = ST_SEARCH;
                        end
                        ST_SEARCH: begin
                            w_gap_nxt = w_is_gap;
                            if (w_is_gap) begin
                                w_state_nxt = ST_SYNC;
                                w_tooth_nxt = '0;
                            end
                        end
                        ST_SYNC: begin
                            w_gap_nxt = w_is_gap;
                            if (w_is_gap) begin
                                // A gap is only expected after the last tooth;
                                // anywhere else lock is lost (tooth holds).
                                if (r_tooth == c_last_tooth) begin
                                    w_tooth_nxt = '0;
                                end else begin
                                    w_state_nxt = ST_SEARCH;
                                end
                            end else if (r_tooth == c_last_tooth) begin
                                // Gap was due but did not arrive.
                                w_state_nxt = ST_SEARCH;
                            end else begin
                                w_tooth_nxt = r_tooth + TOOTH_W'(1);
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end else if (!w_timer_sat) begin
                w_timer_nxt = r_timer + WIDTH'(1);
                // Reaching all-ones means the engine stopped or the sensor
                // failed: drop the timing reference but keep the periods.
                if (w_timer_nxt == c_timer_max) begin
                    w_stall_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_period      <= '0;
            r_period_prev <= '0;
            r_tooth       <= '0;
            r_cap_valid   <= 1'b0;
            r_gap         <= 1'b0;
            r_stall       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_period      <= w_period_nxt;
            r_period_prev <= w_period_prev_nxt;
            r_tooth       <= w_tooth_nxt;
            r_cap_valid   <= w_cap_valid_nxt;
            r_gap         <= w_gap_nxt;
            r_stall       <= w_stall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cap_valid   = r_cap_valid;
    assign period      = r_period;
    assign period_prev = r_period_prev;
    assign gap         = r_gap;
    assign tooth       = r_tooth;
    // Decoded straight from the state register so sync falls in the same
    // cycle the state leaves ST_SYNC.
    assign sync        = (r_state == ST_SYNC);
    assign stall       = r_stall;

endmodule : tooth_capture
`default_nettype wire

// File: tb/tb_tooth_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_tooth_capture
// Description : Self-checking bench for tooth_capture. A default-width
//               instance is checked against a wheel-level reference model;
//               a WIDTH=8 instance sharing the same inputs covers timer
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tooth_capture;
    import hwag_pkg::*;

    localparam int  W     = 24;
    localparam int  TW    = 6;
    localparam int  TEETH = 58;
    localparam longint ONES = (64'd1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic edge_pulse = 1'b0;

    logic          cap_valid, gap, sync, stall;
    logic [W-1:0]  period, period_prev;
    logic [TW-1:0] tooth;
    logic          cap_valid8, gap8, sync8, stall8;
    logic [7:0]    period8, period_prev8;
    logic [TW-1:0] tooth8;

    tooth_capture dut (
        .clk(clk), .rst(rst), .ena(ena), .edge_pulse(edge_pulse),
        .cap_valid(cap_valid), .period(period), .period_prev(period_prev),
        .gap(gap), .tooth(tooth), .sync(sync), .stall(stall)
    );

    tooth_capture #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ena(ena), .edge_pulse(edge_pulse),
        .cap_valid(cap_valid8), .period(period8), .period_prev(period_prev8),
        .gap(gap8), .tooth(tooth8), .sync(sync8), .stall(stall8)
    );

    always #5 clk = ~clk;

    wire [2*W+TW+3:0] obs  = {cap_valid, gap, sync, stall, tooth, period, period_prev};
    wire [2*8+TW+3:0] obs8 = {cap_valid8, gap8, sync8, stall8, tooth8, period8, period_prev8};

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Wheel-level reference model
    // ------------------------------------------------------------------
    longint m_since;    // enabled cycles since last accepted edge
    bit     m_armed;    // an edge has started a measurement
    int     m_ncap;     // captures since the measurement started
    bit     m_sync;
    int     m_tooth;
    longint m_period, m_prev;
    bit     e_cap, e_gap;

    function automatic void model_reset();
        m_since = 0; m_armed = 0; m_ncap = 0; m_sync = 0; m_tooth = 0;
        m_period = 0; m_prev = 0; e_cap = 0; e_gap = 0;
    endfunction

    function automatic void model_edge(longint iv);
        e_cap = 0; e_gap = 0;
        if (!m_armed || iv >= ONES) begin
            m_armed = 1; m_ncap = 0; m_sync = 0;
            return;
        end
        e_cap = 1;
        m_prev = m_period;
        m_period = iv;
        m_ncap++;
        if (m_ncap < 3) return;
        e_gap = (m_period > 2 * m_prev);
        if (m_sync) begin
            if (e_gap && m_tooth == TEETH - 1)       m_tooth = 0;
            else if (!e_gap && m_tooth < TEETH - 1)  m_tooth = m_tooth + 1;
            else                                     m_sync = 0;
        end else if (e_gap) begin
            m_sync = 1; m_tooth = 0;
        end
    endfunction

    function automatic logic [2*W+TW+3:0] exp_vec();
        return {e_cap, e_gap, m_sync, (m_since >= ONES), TW'(m_tooth), W'(m_period), W'(m_prev)};
    endfunction

    function automatic state_e exp_state();
        if (!m_armed)    return ST_IDLE;
        if (m_ncap == 0) return ST_ARM;
        if (m_ncap == 1) return ST_FILL;
        return m_sync ? ST_SYNC : ST_SEARCH;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------
    task automatic cyc(input bit e, input bit en);
        ena = en; edge_pulse = e;
        @(posedge clk); #1;
        edge_pulse = 1'b0;
        e_cap = 0; e_gap = 0;
        if (en) begin
            m_since++;
            if (e) begin model_edge(m_since); m_since = 0; end
        end
    endtask

    // Next edge n enabled cycles after the previous one.
    task automatic tooth_gap(input int n);
        for (int i = 0; i < n - 1; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; edge_pulse = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
        n_tests++;
        if (obs8 !== '0) begin n_fail++; $display("FAIL reset_outputs8: got %h want 0", obs8); end
        n_tests++;
        if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_IDLE); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_captures();
        tooth_gap(100);
        n_tests++;
        if (cap_valid !== 1'b0 || dut.r_state !== ST_ARM) begin
            n_fail++; $display("FAIL first_edge: cap_valid %b state %0d want 0 / ARM", cap_valid, dut.r_state);
        end
        tooth_gap(100);
        n_tests++;
        if (cap_valid !== 1'b1 || period !== W'(100)) begin
            n_fail++; $display("FAIL first_capture: cap_valid %b period %0d want 1 / 100", cap_valid, period);
        end
        n_tests++;
        if (obs !== exp_vec()) begin n_fail++; $display("FAIL first_capture_model: got %h want %h", obs, exp_vec()); end
        cyc(1'b0, 1'b1);
        n_tests++;
        if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL cap_pulse_width: got %b want 0", cap_valid); end
        tooth_gap(99);
        n_tests++;
        if (dut.r_state !== ST_SEARCH || gap !== 1'b0) begin
            n_fail++; $display("FAIL fill_to_search: state %0d gap %b want %0d / 0", dut.r_state, gap, ST_SEARCH);
        end
        tooth_gap(100);
        n_tests++;
        if (dut.r_state !== exp_state() || obs !== exp_vec()) begin
            n_fail++; $display("FAIL search_hold: state %0d obs %h want %0d / %h", dut.r_state, obs, exp_state(), exp_vec());
        end
    endtask

    task automatic test_sync_lock();
        tooth_gap(300);
        n_tests++;
        if (gap !== 1'b1 || period !== W'(300) || tooth !== '0 || sync !== 1'b1) begin
            n_fail++; $display("FAIL gap_lock: gap %b period %0d tooth %0d sync %b want 1/300/0/1", gap, period, tooth, sync);
        end
        for (int t = 0; t < 57; t++) begin
            tooth_gap(100);
            n_tests++;
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL tooth_track[%0d]: got %h want %h", t, obs, exp_vec()); end
        end
        n_tests++;
        if (tooth !== TW'(57)) begin n_fail++; $display("FAIL last_tooth: got %0d want 57", tooth); end
        tooth_gap(300);
        n_tests++;
        if (gap !== 1'b1 || sync !== 1'b1 || tooth !== '0) begin
            n_fail++; $display("FAIL gap_keep_sync: gap %b sync %b tooth %0d want 1/1/0", gap, sync, tooth);
        end
    endtask

    task automatic test_missing_gap();
        for (int t = 0; t < 57; t++) tooth_gap(100);
        tooth_gap(100);
        n_tests++;
        if (cap_valid !== 1'b1 || sync !== 1'b0 || dut.r_state !== ST_SEARCH || tooth !== TW'(57)) begin
            n_fail++; $display("FAIL missing_gap: cap %b sync %b state %0d tooth %0d want 1/0/%0d/57",
                               cap_valid, sync, dut.r_state, tooth, ST_SEARCH);
        end
        tooth_gap(300);
        n_tests++;
        if (sync !== 1'b1 || tooth !== '0) begin n_fail++; $display("FAIL missing_gap_relock: sync %b tooth %0d want 1/0", sync, tooth); end
    endtask

    task automatic test_early_gap();
        for (int t = 0; t < 20; t++) tooth_gap(100);
        n_tests++;
        if (tooth !== TW'(20) || sync !== 1'b1) begin n_fail++; $display("FAIL pre_early: tooth %0d sync %b want 20/1", tooth, sync); end
        tooth_gap(300);
        n_tests++;
        if (gap !== 1'b1 || sync !== 1'b0 || dut.r_state !== ST_SEARCH || tooth !== TW'(20)) begin
            n_fail++; $display("FAIL early_gap: gap %b sync %b state %0d tooth %0d want 1/0/%0d/20",
                               gap, sync, dut.r_state, tooth, ST_SEARCH);
        end
        for (int t = 0; t < 37; t++) tooth_gap(100);
        tooth_gap(300);
        n_tests++;
        if (sync !== 1'b1 || tooth !== '0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL early_gap_relock: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cyc((i % 5) == 0, 1'b0);
            if ((i % 5) == 0) begin
                n_tests++;
                if (cap_valid !== 1'b0 || gap !== 1'b0) begin
                    n_fail++; $display("FAIL disabled_edge[%0d]: cap %b gap %b want 0/0", i, cap_valid, gap);
                end
            end
        end
        n_tests++;
        if (dut.r_timer !== W'(41)) begin n_fail++; $display("FAIL timer_frozen: got %0d want 41", dut.r_timer); end
        for (int i = 0; i < 59; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        n_tests++;
        if (period !== W'(100) || tooth !== TW'(1) || obs !== exp_vec()) begin
            n_fail++; $display("FAIL enable_resume: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int base, mode, early;
            base  = int'($urandom_range(20, 60));
            mode  = int'($urandom_range(0, 5));   // 0: missing gap, 1: early gap
            early = int'($urandom_range(3, 50));
            for (int t = 0; t < 58; t++) begin
                int p;
                p = base - base / 10 + int'($urandom_range(0, base / 5));
                if (t == 57 && mode != 0) p = 3 * base + int'($urandom_range(0, base / 4));
                if (mode == 1 && t == early) p = 3 * base;
                for (int i = 0; i < p - 1; i++) cyc(1'b0, $urandom_range(0, 9) != 0);
                cyc(1'b1, 1'b1);
                n_tests++;
                if (obs !== exp_vec() || dut.r_state !== exp_state()) begin
                    n_fail++; $display("FAIL random[%0d.%0d]: obs %h state %0d want %h / %0d",
                                       r, t, obs, dut.r_state, exp_vec(), exp_state());
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tooth_gap(10);
        for (int t = 0; t < 60; t++) tooth_gap(10);
        tooth_gap(30);
        n_tests++;
        if (sync8 !== 1'b1 || obs8 !== {e_cap, e_gap, m_sync, 1'b0, TW'(m_tooth), 8'(m_period), 8'(m_prev)}) begin
            n_fail++; $display("FAIL narrow_sync: got %h sync %b", obs8, sync8);
        end
        for (int i = 0; i < 253; i++) cyc(1'b0, 1'b1);
        n_tests++;
        if (stall8 !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %b want 0", stall8); end
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        n_tests++;
        if (stall8 !== 1'b1 || sync8 !== 1'b0 || dut8.r_state !== ST_IDLE || period8 !== 8'd30 || period_prev8 !== 8'd10) begin
            n_fail++; $display("FAIL stall_set: stall %b sync %b state %0d period %0d prev %0d want 1/0/IDLE/30/10",
                               stall8, sync8, dut8.r_state, period8, period_prev8);
        end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL wide_no_stall: got %b want 0", stall); end
        cyc(1'b1, 1'b1);
        n_tests++;
        if (cap_valid8 !== 1'b0 || stall8 !== 1'b0 || dut8.r_state !== ST_ARM) begin
            n_fail++; $display("FAIL stall_rearm: cap %b stall %b state %0d want 0/0/%0d", cap_valid8, stall8, dut8.r_state, ST_ARM);
        end
    endtask

    task automatic test_async_reset();
        state_e seq [5];
        do_reset();
        tooth_gap(10);
        for (int t = 0; t < 60; t++) tooth_gap(10);
        tooth_gap(30);
        for (int t = 0; t < 25; t++) tooth_gap(10);
        n_tests++;
        if (sync !== 1'b1 || sync8 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sync: %b %b want 1 1", sync, sync8); end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== '0 || obs8 !== '0 || dut.r_state !== ST_IDLE || dut8.r_state !== ST_IDLE) begin
            n_fail++; $display("FAIL async_reset: obs %h obs8 %h states %0d %0d want 0", obs, obs8, dut.r_state, dut8.r_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        seq = '{ST_ARM, ST_FILL, ST_SEARCH, ST_SEARCH, ST_SYNC};
        for (int k = 0; k < 5; k++) begin
            tooth_gap((k % 2 == 0) ? 30 : 10);
            n_tests++;
            if (dut.r_state !== seq[k] || obs !== exp_vec()) begin
                n_fail++; $display("FAIL resync_path[%0d]: state %0d obs %h want %0d / %h", k, dut.r_state, obs, seq[k], exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_first_captures();
        test_sync_lock();
        test_missing_gap();
        test_early_gap();
        test_enable();
        test_random();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tooth_capture
`default_nettype wire
